// File: rtl/phys_reg_read_if.sv
// Issue, writeback and execute-side signals of the physical register-read stage.
interface phys_reg_read_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int PREG_BITS   = 6,
    parameter int ISSUE_WIDTH = 137,
    parameter int ROB_BITS    = 6
);
    logic                   FREEZE;
    logic                   Valid_Instruction_IN;
    logic                   Mem_Instruction_IN;
    logic [ISSUE_WIDTH-1:0] issueData_IN;
    logic                   stall_OUT;
    logic                   wbA_valid_IN;
    logic [PREG_BITS-1:0]   wbA_reg_IN;
    logic [DATA_WIDTH-1:0]  wbA_data_IN;
    logic                   wbB_valid_IN;
    logic [PREG_BITS-1:0]   wbB_reg_IN;
    logic [DATA_WIDTH-1:0]  wbB_data_IN;
    logic                   ex_ready_IN;
    logic                   ex_valid_OUT;
    logic                   ex_mem_OUT;
    logic [DATA_WIDTH-1:0]  ex_src1_OUT;
    logic [DATA_WIDTH-1:0]  ex_src2_OUT;
    logic [DATA_WIDTH-1:0]  ex_imm_OUT;
    logic [PREG_BITS-1:0]   ex_dest_OUT;
    logic                   ex_needDest_OUT;
    logic [5:0]             ex_aluCtl_OUT;
    logic [ROB_BITS-1:0]    ex_rob_OUT;
    logic [31:0]            ex_pc_OUT;
    logic [31:0]            ex_instr_OUT;

    modport slave (
        input  FREEZE, Valid_Instruction_IN, Mem_Instruction_IN, issueData_IN,
        input  wbA_valid_IN, wbA_reg_IN, wbA_data_IN, wbB_valid_IN, wbB_reg_IN, wbB_data_IN,
        input  ex_ready_IN,
        output stall_OUT, ex_valid_OUT, ex_mem_OUT, ex_src1_OUT, ex_src2_OUT, ex_imm_OUT,
        output ex_dest_OUT, ex_needDest_OUT, ex_aluCtl_OUT, ex_rob_OUT, ex_pc_OUT, ex_instr_OUT
    );

    modport master (
        output FREEZE, Valid_Instruction_IN, Mem_Instruction_IN, issueData_IN,
        output wbA_valid_IN, wbA_reg_IN, wbA_data_IN, wbB_valid_IN, wbB_reg_IN, wbB_data_IN,
        output ex_ready_IN,
        input  stall_OUT, ex_valid_OUT, ex_mem_OUT, ex_src1_OUT, ex_src2_OUT, ex_imm_OUT,
        input  ex_dest_OUT, ex_needDest_OUT, ex_aluCtl_OUT, ex_rob_OUT, ex_pc_OUT, ex_instr_OUT
    );
endinterface

// File: rtl/phys_reg_read.sv
// Register-read stage: 64x32 PRF with writeback bypass, 2-entry snooping skid buffer.
// Optional: PREG_ZERO_HARDWIRED_EN makes physical register 0 a constant zero.
module phys_reg_read #(
    parameter int DATA_WIDTH  = 32,
    parameter int PREG_BITS   = 6,
    parameter int ISSUE_WIDTH = 137,
    parameter int ROB_BITS    = 6
) (
    input logic            CLK,
    input logic            RESET,
    phys_reg_read_if.slave bus
);
    localparam int NREGS = 1 << PREG_BITS;

    typedef struct packed {
        logic                  mem;
        logic                  imm_src;
        logic                  need_dest;
        logic [PREG_BITS-1:0]  src1;
        logic [PREG_BITS-1:0]  src2;
        logic [PREG_BITS-1:0]  dest;
        logic [DATA_WIDTH-1:0] op1;
        logic [DATA_WIDTH-1:0] op2;
        logic [DATA_WIDTH-1:0] imm;
        logic [5:0]            alu;
        logic [ROB_BITS-1:0]   rob;
        logic [31:0]           pc;
        logic [31:0]           instr;
    } ent_t;

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} cnt_e;

    logic [DATA_WIDTH-1:0] rf_q [NREGS];
    ent_t                  ent_q [2];
    ent_t                  ent_d [2];
    ent_t                  new_ent, head;
    cnt_e                  cnt_q, cnt_d;
    logic                  head_q, head_d, tail_q, tail_d;
    logic                  push, pop;
    logic                  unused_bits;

    function automatic logic hit(input logic v, input logic [PREG_BITS-1:0] wr,
                                 input logic [PREG_BITS-1:0] r);
`ifdef PREG_ZERO_HARDWIRED_EN
        return v && (wr == r) && (r != '0);
`else
        return v && (wr == r);
`endif
    endfunction

    // Same-cycle writeback value for register r, B taking precedence over A.
    function automatic logic [DATA_WIDTH-1:0] fwd(input logic [PREG_BITS-1:0] r,
                                                  input logic [DATA_WIDTH-1:0] cur);
        logic [DATA_WIDTH-1:0] v;
        v = cur;
        if (hit(bus.wbA_valid_IN, bus.wbA_reg_IN, r)) v = bus.wbA_data_IN;
        if (hit(bus.wbB_valid_IN, bus.wbB_reg_IN, r)) v = bus.wbB_data_IN;
        return v;
    endfunction

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
        end else begin
            if (hit(bus.wbA_valid_IN, bus.wbA_reg_IN, bus.wbA_reg_IN)) rf_q[bus.wbA_reg_IN] <= bus.wbA_data_IN;
            if (hit(bus.wbB_valid_IN, bus.wbB_reg_IN, bus.wbB_reg_IN)) rf_q[bus.wbB_reg_IN] <= bus.wbB_data_IN;
        end
    end

    assign push = bus.Valid_Instruction_IN && !bus.stall_OUT && !bus.FREEZE;
    assign pop  = bus.ex_ready_IN && bus.ex_valid_OUT && !bus.FREEZE;

    assign unused_bits = ^{bus.issueData_IN[104:98], bus.issueData_IN[89], bus.issueData_IN[82]};

    always_comb begin
        new_ent           = '0;
        new_ent.mem       = bus.Mem_Instruction_IN;
        new_ent.pc        = bus.issueData_IN[136:105];
        new_ent.imm_src   = bus.issueData_IN[97];
        new_ent.need_dest = bus.issueData_IN[96];
        new_ent.dest      = bus.issueData_IN[95:90];
        new_ent.src2      = bus.issueData_IN[88:83];
        new_ent.src1      = bus.issueData_IN[81:76];
        new_ent.imm       = DATA_WIDTH'($signed(bus.issueData_IN[75:44]));
        new_ent.alu       = bus.issueData_IN[43:38];
        new_ent.rob       = bus.issueData_IN[37:32];
        new_ent.instr     = bus.issueData_IN[31:0];
        new_ent.op1       = fwd(new_ent.src1, rf_q[new_ent.src1]);
        new_ent.op2       = new_ent.imm_src ? new_ent.imm : fwd(new_ent.src2, rf_q[new_ent.src2]);
    end

    // Buffered operands track late producers; immediates are never overwritten.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            ent_d[i]     = ent_q[i];
            ent_d[i].op1 = fwd(ent_q[i].src1, ent_q[i].op1);
            if (!ent_q[i].imm_src) ent_d[i].op2 = fwd(ent_q[i].src2, ent_q[i].op2);
        end
        if (push) ent_d[tail_q] = new_ent;
    end

    always_comb begin
        cnt_d  = cnt_q;
        head_d = head_q;
        tail_d = tail_q;
        if (push) tail_d = ~tail_q;
        if (pop)  head_d = ~head_q;
        case (cnt_q)
            EMPTY:   if (push) cnt_d = ONE;
            ONE:     if (push && !pop) cnt_d = FULL;
                     else if (pop && !push) cnt_d = EMPTY;
            FULL:    if (pop) cnt_d = ONE;
            default: cnt_d = EMPTY;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt_q    <= EMPTY;
            head_q   <= 1'b0;
            tail_q   <= 1'b0;
            ent_q[0] <= '0;
            ent_q[1] <= '0;
        end else begin
            cnt_q    <= cnt_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            ent_q[0] <= ent_d[0];
            ent_q[1] <= ent_d[1];
        end
    end

    assign bus.ex_valid_OUT    = (cnt_q != EMPTY);
    assign bus.stall_OUT       = (cnt_q == FULL);
    assign head                = bus.ex_valid_OUT ? ent_q[head_q] : '0;
    assign bus.ex_mem_OUT      = head.mem;
    assign bus.ex_src1_OUT     = head.op1;
    assign bus.ex_src2_OUT     = head.op2;
    assign bus.ex_imm_OUT      = head.imm;
    assign bus.ex_dest_OUT     = head.dest;
    assign bus.ex_needDest_OUT = head.need_dest;
    assign bus.ex_aluCtl_OUT   = head.alu;
    assign bus.ex_rob_OUT      = head.rob;
    assign bus.ex_pc_OUT       = head.pc;
    assign bus.ex_instr_OUT    = head.instr;
endmodule

// File: tb/tb_phys_reg_read.sv
// Directed + random bench; reference is an architectural register array plus an in-order packet queue.
module tb_phys_reg_read;
    logic clk, rst;
    phys_reg_read_if bus ();

    phys_reg_read dut (.CLK(clk), .RESET(rst), .bus(bus));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic         mem;
        logic [136:0] d;
    } pkt_t;

    logic [31:0] m_rf [64];
    pkt_t        q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_rf[i] = '0;
        q.delete();
    endtask

    task automatic model_wr(input logic [5:0] r, input logic [31:0] v);
`ifdef PREG_ZERO_HARDWIRED_EN
        if (r != 6'd0) m_rf[r] = v;
`else
        m_rf[r] = v;
`endif
    endtask

    // A buffered operand always equals the register's current architectural value.
    function automatic logic [179:0] exp_vec(input pkt_t p);
        logic [31:0] s1, s2;
        s1 = m_rf[p.d[81:76]];
        s2 = p.d[97] ? p.d[75:44] : m_rf[p.d[88:83]];
        return {p.mem, s1, s2, p.d[75:44], p.d[95:90], p.d[96], p.d[43:38], p.d[37:32],
                p.d[136:105], p.d[31:0]};
    endfunction

    function automatic logic [179:0] obs_vec();
        return {bus.ex_mem_OUT, bus.ex_src1_OUT, bus.ex_src2_OUT, bus.ex_imm_OUT, bus.ex_dest_OUT,
                bus.ex_needDest_OUT, bus.ex_aluCtl_OUT, bus.ex_rob_OUT, bus.ex_pc_OUT, bus.ex_instr_OUT};
    endfunction

    function automatic logic [136:0] mk(input logic [31:0] pc, input logic imms,
                                        input logic [5:0] s2, input logic [5:0] s1,
                                        input logic [31:0] imm);
        logic [136:0] d;
        for (int i = 0; i < 137; i++) d[i] = 1'($urandom_range(0, 1));
        d[136:105] = pc;
        d[97]      = imms;
        d[88:83]   = s2;
        d[81:76]   = s1;
        d[75:44]   = imm;
        return d;
    endfunction

    task automatic idle();
        bus.FREEZE = 0; bus.Valid_Instruction_IN = 0; bus.Mem_Instruction_IN = 0;
        bus.issueData_IN = '0; bus.ex_ready_IN = 0;
        bus.wbA_valid_IN = 0; bus.wbA_reg_IN = '0; bus.wbA_data_IN = '0;
        bus.wbB_valid_IN = 0; bus.wbB_reg_IN = '0; bus.wbB_data_IN = '0;
    endtask

    task automatic issue(input logic [136:0] d, input logic mem);
        bus.Valid_Instruction_IN = 1; bus.issueData_IN = d; bus.Mem_Instruction_IN = mem;
    endtask

    task automatic check_out();
        chk("ex_valid", 256'(bus.ex_valid_OUT), 256'(q.size() != 0));
        chk("stall", 256'(bus.stall_OUT), 256'(q.size() == 2));
        if (q.size() != 0) chk("head_pkt", 256'(obs_vec()), 256'(exp_vec(q[0])));
        else               chk("idle_zero", 256'(obs_vec()), 256'(0));
    endtask

    // Check current outputs, then advance one clock and update the reference.
    task automatic cycle();
        bit   pu, po;
        pkt_t p;
        check_out();
        pu = bus.Valid_Instruction_IN && q.size() < 2 && !bus.FREEZE;
        po = bus.ex_ready_IN && q.size() != 0 && !bus.FREEZE;
        if (bus.Valid_Instruction_IN && q.size() == 2)
            $display("protocol error: issue while stall_OUT high, entry dropped (t=%0t)", $time);
        @(posedge clk);
        if (bus.wbA_valid_IN) model_wr(bus.wbA_reg_IN, bus.wbA_data_IN);
        if (bus.wbB_valid_IN) model_wr(bus.wbB_reg_IN, bus.wbB_data_IN);
        if (po) void'(q.pop_front());
        if (pu) begin
            p.mem = bus.Mem_Instruction_IN;
            p.d   = bus.issueData_IN;
            q.push_back(p);
        end
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] pc2, r0_exp;
        idle();
        model_reset();
        rst = 1;
        #12 rst = 0;
        @(negedge clk);

        // Write then read
        bus.wbA_valid_IN = 1; bus.wbA_reg_IN = 6'd5; bus.wbA_data_IN = 32'h1234;
        cycle();
        idle(); issue(mk(32'h100, 0, 6'd6, 6'd5, 32'h0), 0); bus.ex_ready_IN = 1;
        cycle();
        idle(); bus.ex_ready_IN = 1;
        chk("t1_valid", 256'(bus.ex_valid_OUT), 256'(1));
        chk("t1_src1", 256'(bus.ex_src1_OUT), 256'(32'h1234));
        chk("t1_src2", 256'(bus.ex_src2_OUT), 256'(32'h0));
        cycle();

        // Same-cycle bypass
        idle(); issue(mk(32'h104, 0, 6'd1, 6'd7, 32'h0), 1); bus.ex_ready_IN = 1;
        bus.wbB_valid_IN = 1; bus.wbB_reg_IN = 6'd7; bus.wbB_data_IN = 32'hBEEF;
        cycle();
        idle(); bus.ex_ready_IN = 1;
        chk("bypass_src1", 256'(bus.ex_src1_OUT), 256'(32'hBEEF));
        cycle();

        // Backpressure, plus one dropped entry while full
        idle(); issue(mk(32'h200, 1, 6'd2, 6'd3, 32'hFFFF_FFF0), 0);
        cycle();
        pc2 = 32'h204;
        idle(); issue(mk(pc2, 0, 6'd4, 6'd5, 32'h8), 1);
        cycle();
        chk("bp_stall", 256'(bus.stall_OUT), 256'(1));
        idle(); issue(mk(32'h208, 0, 6'd1, 6'd1, 32'h0), 0);
        cycle();
        idle(); bus.ex_ready_IN = 1;
        cycle();
        chk("bp_stall_drop", 256'(bus.stall_OUT), 256'(0));
        chk("bp_order", 256'(bus.ex_pc_OUT), 256'(pc2));
        cycle();
        chk("bp_drained", 256'(bus.ex_valid_OUT), 256'(0));

        // Snoop of a stalled entry
        idle(); issue(mk(32'h300, 0, 6'd9, 6'd2, 32'h0), 0);
        cycle();
        idle(); bus.wbA_valid_IN = 1; bus.wbA_reg_IN = 6'd9; bus.wbA_data_IN = 32'h55;
        cycle();
        idle();
        chk("snoop_src2", 256'(bus.ex_src2_OUT), 256'(32'h55));
        bus.ex_ready_IN = 1;
        cycle();

        // Dual write conflict
        idle();
        bus.wbA_valid_IN = 1; bus.wbA_reg_IN = 6'd3; bus.wbA_data_IN = 32'h1;
        bus.wbB_valid_IN = 1; bus.wbB_reg_IN = 6'd3; bus.wbB_data_IN = 32'h2;
        cycle();
        idle(); issue(mk(32'h400, 0, 6'd0, 6'd3, 32'h0), 0); bus.ex_ready_IN = 1;
        cycle();
        idle(); bus.ex_ready_IN = 1;
        chk("dual_wr_B_wins", 256'(bus.ex_src1_OUT), 256'(32'h2));
        cycle();

        // Register 0 write
        idle(); bus.wbA_valid_IN = 1; bus.wbA_reg_IN = 6'd0; bus.wbA_data_IN = 32'hFF;
        cycle();
        idle(); issue(mk(32'h500, 0, 6'd0, 6'd0, 32'h0), 0); bus.ex_ready_IN = 1;
        cycle();
`ifdef PREG_ZERO_HARDWIRED_EN
        r0_exp = 32'h0;
`else
        r0_exp = 32'hFF;
`endif
        idle(); bus.ex_ready_IN = 1;
        chk("reg0_read", 256'(bus.ex_src1_OUT), 256'(r0_exp));
        cycle();

        // Asynchronous reset while stalled
        idle(); issue(mk(32'h600, 0, 6'd1, 6'd2, 32'h0), 0);
        cycle();
        issue(mk(32'h604, 0, 6'd3, 6'd4, 32'h0), 0);
        cycle();
        chk("rst_pre_stall", 256'(bus.stall_OUT), 256'(1));
        #2 rst = 1;
        #1;
        chk("rst_valid", 256'(bus.ex_valid_OUT), 256'(0));
        chk("rst_stall", 256'(bus.stall_OUT), 256'(0));
        chk("rst_outs", 256'(obs_vec()), 256'(0));
        idle();
        #1 rst = 0;
        model_reset();
        @(negedge clk);
        issue(mk(32'h700, 0, 6'd9, 6'd5, 32'h0), 0); bus.ex_ready_IN = 1;
        cycle();

        // Random traffic with freeze, collisions and immediates
        for (int n = 0; n < 800; n++) begin
            idle();
            bus.FREEZE      = ($urandom_range(0, 9) == 0);
            bus.ex_ready_IN = ($urandom_range(0, 9) < 6);
            if (q.size() < 2 && $urandom_range(0, 9) < 6)
                issue(mk($urandom, 1'($urandom_range(0, 3) == 0), 6'($urandom_range(0, 15)),
                         6'($urandom_range(0, 15)), $urandom), 1'($urandom_range(0, 1)));
            bus.wbA_valid_IN = 1'($urandom_range(0, 1));
            bus.wbA_reg_IN   = 6'($urandom_range(0, 15));
            bus.wbA_data_IN  = $urandom;
            bus.wbB_valid_IN = 1'($urandom_range(0, 1));
            bus.wbB_reg_IN   = 6'($urandom_range(0, 15));
            bus.wbB_data_IN  = $urandom;
            cycle();
        end
        idle();
        check_out();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/phys_reg_read.md
Name: phys_reg_read

Overview:
- Register-read stage directly downstream of the issue stage.
- Accepts one issued IQ/LSQ entry per cycle and reads both source operands from a 64x32 physical register file, with writeback bypass.
- Holds results in a 2-entry skid buffer and presents a fully-resolved operand packet to execute/memory.
- Owns the physical register file; the ALU and load/store writeback ports write it.

Parameters:
- DATA_WIDTH, 32, operand/register width
- PREG_BITS, 6, physical register specifier width (2^PREG_BITS registers)
- ISSUE_WIDTH, 137, width of the issued entry
- ROB_BITS, 6, ROB pointer width

Ports:
- CLK  in  1  clock
- RESET  in  1  asynchronous active-high reset
- FREEZE  in  1  holds buffer state; register-file writes still commit
- Valid_Instruction_IN  in  1  issued entry valid this cycle
- Mem_Instruction_IN  in  1  entry came from LSQ
- issueData_IN  in  ISSUE_WIDTH  issued entry
- stall_OUT  out  1  buffer full; issue must not present a new entry
- wbA_valid_IN  in  1  ALU writeback valid
- wbA_reg_IN  in  PREG_BITS  ALU writeback register
- wbA_data_IN  in  DATA_WIDTH  ALU writeback data
- wbB_valid_IN / wbB_reg_IN / wbB_data_IN  in  1 / PREG_BITS / DATA_WIDTH  load/store writeback
- ex_ready_IN  in  1  execute accepts head packet
- ex_valid_OUT  out  1  head packet valid
- ex_mem_OUT  out  1  head is memory op
- ex_src1_OUT  out  DATA_WIDTH  operand 1
- ex_src2_OUT  out  DATA_WIDTH  operand 2, or sign-extended immediate when immediate-source
- ex_imm_OUT  out  DATA_WIDTH  immediate (needed by loads/stores for address)
- ex_dest_OUT  out  PREG_BITS  destination register
- ex_needDest_OUT  out  1  destination is written
- ex_aluCtl_OUT  out  6  ALU control
- ex_rob_OUT  out  ROB_BITS  ROB pointer
- ex_pc_OUT  out  32  PC
- ex_instr_OUT  out  32  raw instruction

Behaviour:
- Entry fields: [136:105] PC, [103:98] link/jumpReg/jump/branch/MemWrite/MemRead, [97] immSrc, [96] needDest, [95:90] dest, [88:83] src2, [81:76] src1, [75:44] imm, [43:38] aluCtl, [37:32] ROB, [31:0] instr.
- Register file: 64x32, two write ports, two read ports.
  - All entries reset to 0.
  - Writes occur on the rising edge whenever wb*_valid_IN is set, regardless of FREEZE.
  - When A and B target the same register in the same cycle, B wins.
- Read bypass: a source matching a same-cycle valid writeback takes the writeback data (B over A), otherwise the array value.
- Skid buffer: 2 entries, head/tail pointers and a 2-bit count. States EMPTY(0), ONE(1), FULL(2).
  - Push when Valid_Instruction_IN && !stall_OUT && !FREEZE.
  - Pop when ex_ready_IN && ex_valid_OUT && !FREEZE.
  - Push and pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo 2.
- Latency: an entry accepted at edge N appears on ex_* after edge N (visible in cycle N+1).
- ex_valid_OUT = count!=0. stall_OUT = count==2, combinational from registered count.
- Valid_Instruction_IN asserted while stall_OUT is high: entry is dropped. This is a protocol error; the bench flags it.
- Operand snoop: every buffered entry compares its src1/src2 against both writeback ports each cycle and replaces the stored operand on a match. This keeps operands correct for producers that complete after the read. Snoop continues during FREEZE.
- immSrc=1: src2 operand = imm and is not snooped.
- ex_* outputs are driven from the head entry; ex_* values are don't-care when ex_valid_OUT=0 and are held at 0 by design.
- Reset (asynchronous, any time including mid-stall): count=0, pointers=0, all ex_* outputs 0, stall_OUT=0, register file cleared.

Optional Feature:
- Macro PREG_ZERO_HARDWIRED_EN.
- Defined: physical register 0 always reads 0; writes to it are discarded; bypass and snoop never match register 0.
- Undefined: register 0 is an ordinary register.

Test Plan:
- Write reg 5=0x1234 via port A; next cycle issue src1=5, src2=6 (reg6=0) with ex_ready=1 -> following cycle ex_valid=1, src1=0x1234, src2=0.
- Same-cycle bypass: issue src1=7 while wbB writes reg7=0xBEEF -> ex_src1=0xBEEF.
- Backpressure: ex_ready=0, issue 2 entries -> stall_OUT=1, count=2; raise ex_ready -> entries exit in order over 2 cycles, stall_OUT drops after first pop.
- Snoop: buffer holds entry with src2=9 stalled; wbA writes reg9=0x55 -> on release ex_src2=0x55.
- Dual write conflict: A and B both write reg3 (0x1, 0x2) -> reg3 reads 0x2. Assert RESET mid-stall -> ex_valid=0, stall=0 immediately.
- With PREG_ZERO_HARDWIRED_EN: write reg0=0xFF -> read src1=0 gives 0.
